conv3x3_window_mac: RTL and testbench

//  Downstream consumer of the row delay-line stage in the convolution datapath.

---
 rtl/conv3x3_window_mac.sv | 172 +++++++++++++++++
 tb/tb_conv3x3_window_mac.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_mac.sv
// 3x3 sliding-window convolver: builds a window from three row-aligned pixel taps
// and runs a 9-tap signed kernel through a registered multiply / row-sum / total pipeline.
module conv3x3_window_mac #(
  parameter int D = 16,
  parameter int W = 28,
  parameter int H = 28
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_w_load,
  input  logic signed [D-1:0]   i_w_data,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic signed [D-1:0]   i_row0,
  input  logic signed [D-1:0]   i_row1,
  input  logic signed [D-1:0]   i_row2,
  output logic                  o_valid,
  output logic signed [2*D+3:0] o_data,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} stateT;

  stateT r_state;
  stateT w_nextState;
  logic  [1:0] r_flushCnt;
  logic  w_doneNext;

  logic signed [D-1:0]     r_w [9];
  logic        [3:0]       r_widx;
  logic        [CW-1:0]    r_col;
  logic        [RW-1:0]    r_row;
  logic signed [D-1:0]     r_win [3][3];
  logic                    r_s1Valid, r_s1Last;
  logic signed [2*D-1:0]   r_prod [9];
  logic                    r_s2Valid, r_s2Last;
  logic signed [2*D+1:0]   r_rowSum [3];
  logic                    r_s3Valid, r_s3Last;
  logic signed [2*D+3:0]   r_data;
  logic                    r_valid, r_last, r_done;

  logic w_accept, w_lastPix, w_winValid;

  assign w_accept   = (r_state == RUN) && i_valid;
  assign w_lastPix  = (r_row == RW'(H - 1)) && (r_col == CW'(W - 1));
  assign w_winValid = (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_flushCnt <= 2'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_flushCnt <= (r_state == FLUSH) ? r_flushCnt + 2'd1 : 2'd0;
      r_done     <= w_doneNext;
    end
  end

  // The final pixel is followed by three drain cycles so the last result leaves with o_done.
  always_comb begin
    w_nextState = r_state;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_nextState = RUN;
      RUN:   if (w_accept && w_lastPix) w_nextState = FLUSH;
      FLUSH: begin
        if (r_flushCnt == 2'd2) begin
          w_nextState = IDLE;
          w_doneNext  = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 9; i++) r_w[i] <= '0;
      r_widx <= 4'd0;
    end else if (r_state == IDLE && i_w_load) begin
      r_w[r_widx] <= i_w_data;
      r_widx      <= (r_widx == 4'd8) ? 4'd0 : r_widx + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == CW'(W - 1)) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Window row 0 holds the oldest row (r-2) so w[0] lines up with the top-left pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 3; k++) r_win[j][k] <= '0;
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int j = 0; j < 3; j++) begin
          r_win[j][0] <= r_win[j][1];
          r_win[j][1] <= r_win[j][2];
        end
        r_win[0][2] <= i_row2;
        r_win[1][2] <= i_row1;
        r_win[2][2] <= i_row0;
      end
      r_s1Valid <= w_accept && w_winValid;
      r_s1Last  <= w_accept && w_lastPix;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 9; i++) r_prod[i] <= '0;
      for (int j = 0; j < 3; j++) r_rowSum[j] <= '0;
      r_s2Valid <= 1'b0;
      r_s2Last  <= 1'b0;
      r_s3Valid <= 1'b0;
      r_s3Last  <= 1'b0;
    end else begin
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 3; k++)
          r_prod[3*j+k] <= (2*D)'(r_win[j][k]) * (2*D)'(r_w[3*j+k]);
      for (int j = 0; j < 3; j++)
        r_rowSum[j] <= (2*D+2)'(r_prod[3*j]) + (2*D+2)'(r_prod[3*j+1])
                     + (2*D+2)'(r_prod[3*j+2]);
      r_s2Valid <= r_s1Valid;
      r_s2Last  <= r_s1Last;
      r_s3Valid <= r_s2Valid;
      r_s3Last  <= r_s2Last;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (r_s3Valid)
        r_data <= (2*D+4)'(r_rowSum[0]) + (2*D+4)'(r_rowSum[1]) + (2*D+4)'(r_rowSum[2]);
      r_valid <= r_s3Valid;
      r_last  <= r_s3Last;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_done  = r_done;
  assign o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Randomized scoreboard bench for conv3x3_window_mac: a direct 3x3 convolution
// over a stored image supplies the expected results, latencies and done pulses.
module tb_conv3x3_window_mac;

  localparam int D = 16;
  localparam int W = 28;
  localparam int H = 28;

  logic                  clk, rst;
  logic                  wLoad, start, valid;
  logic signed [D-1:0]   wData, row0, row1, row2;
  logic                  oValid, oLast, oBusy, oDone;
  logic signed [2*D+3:0] oData;

  conv3x3_window_mac #(.D(D), .W(W), .H(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_w_load(wLoad), .i_w_data(wData),
    .i_start(start), .i_valid(valid), .i_row0(row0), .i_row1(row1), .i_row2(row2),
    .o_valid(oValid), .o_data(oData), .o_last(oLast), .o_busy(oBusy), .o_done(oDone)
  );

  typedef struct {
    longint value;
    bit     last;
    int     cycle;
  } expT;

  expT expQ[$];
  int  doneQ[$];
  int  img[H][W];
  int  mw[9];
  int  mIdx;
  int  cyc;
  int  tests;
  int  fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic longint refConv(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += longint'(mw[3*i+j]) * longint'(img[r-2+i][c-2+j]);
    return s;
  endfunction

  // Monitor: every presented result is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (oValid) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpectedOutput: got data %0d, expected no output", oData);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("data", oData, e.value);
          checkOutput("last", oLast, e.last);
          checkOutput("latency", cyc, e.cycle);
        end
      end
      if (oDone) begin
        if (doneQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL spuriousDone: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          checkOutput("doneCycle", cyc, doneQ.pop_front());
        end
      end
    end
  end

  task automatic loadWeight(input int v);
    wLoad = 1'b1;
    wData = D'(v);
    @(posedge clk);
    #1;
    wLoad = 1'b0;
    mw[mIdx] = v;
    mIdx = (mIdx + 1) % 9;
  endtask

  task automatic setKernel(input int k[9]);
    int pad;
    pad = (9 - mIdx) % 9;
    for (int i = 0; i < pad; i++) loadWeight(int'($urandom_range(0, 99)));
    for (int i = 0; i < 9; i++) loadWeight(k[i]);
  endtask

  task automatic fillImage(input int mode);
    logic signed [D-1:0] t;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        t = D'($urandom);
        case (mode)
          0:       img[r][c] = 32 * r + c;
          1:       img[r][c] = 5;
          2:       img[r][c] = -32768;
          default: img[r][c] = int'(t);
        endcase
      end
  endtask

  // vpat: 0 always valid, 1 alternating, 2 random gaps; abortAt>0 resets mid-frame.
  task automatic applyStimulus(input int mode, input int vpat, input bit startBusy,
                               input bit loadRun, input int abortAt);
    int  r, c, k;
    bit  v;
    expT e;
    fillImage(mode);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r = 0;
    c = 0;
    k = 0;
    while (r < H && !(abortAt > 0 && k == abortAt)) begin
      case (vpat)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      valid = v;
      row0  = D'(img[r][c]);
      row1  = (r >= 1) ? D'(img[r-1][c]) : D'($urandom);
      row2  = (r >= 2) ? D'(img[r-2][c]) : D'($urandom);
      start = startBusy && (r == 10) && (c == 5);
      wLoad = loadRun && (k % 50 == 7);
      wData = D'(7);
      if (v) begin
        if (r >= 2 && c >= 2) begin
          e.value = refConv(r, c);
          e.last  = (r == H - 1) && (c == W - 1);
          e.cycle = cyc + 4;
          expQ.push_back(e);
        end
        if (r == H - 1 && c == W - 1) doneQ.push_back(cyc + 4);
        if (c == W - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
      k++;
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    start = 1'b0;
    wLoad = 1'b0;
    if (abortAt > 0) begin
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abortBusy", oBusy, 0);
      checkOutput("abortValid", oValid, 0);
      checkOutput("abortData", oData, 0);
      expQ.delete();
      doneQ.delete();
      for (int i = 0; i < 9; i++) mw[i] = 0;
      mIdx = 0;
      @(posedge clk);
      #1;
      checkOutput("abortDone", oDone, 0);
      rst = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput("pendingOutputs", expQ.size(), 0);
    checkOutput("pendingDone", doneQ.size(), 0);
    checkOutput("idleAfterFrame", oBusy, 0);
  endtask

  initial begin
    int kern[9];
    rst   = 1'b1;
    wLoad = 1'b0;
    wData = '0;
    start = 1'b0;
    valid = 1'b0;
    row0  = '0;
    row1  = '0;
    row2  = '0;
    tests = 0;
    fails = 0;
    mIdx  = 0;
    for (int i = 0; i < 9; i++) mw[i] = 0;
    #2;
    checkOutput("resetValid", oValid, 0);
    checkOutput("resetData", oData, 0);
    checkOutput("resetLast", oLast, 0);
    checkOutput("resetBusy", oBusy, 0);
    checkOutput("resetDone", oDone, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    setKernel(kern);
    applyStimulus(0, 0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 200)) - 100;
    setKernel(kern);
    applyStimulus(3, 0, 1'b0, 1'b0, 150);

    kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    setKernel(kern);
    applyStimulus(1, 0, 1'b0, 1'b0, 0);

    kern = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    setKernel(kern);
    applyStimulus(2, 0, 1'b0, 1'b0, 0);

    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    setKernel(kern);
    applyStimulus(0, 1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      logic signed [D-1:0] t;
      t = D'($urandom);
      loadWeight(int'(t));
    end
    applyStimulus(3, 2, 1'b0, 1'b0, 0);

    applyStimulus(3, 2, 1'b1, 1'b1, 0);

    begin
      logic signed [D-1:0] t;
      t = D'($urandom);
      loadWeight(int'(t));
    end
    applyStimulus(3, 0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
